// File: rtl/fpga2mcu_pkg.sv
// Package fpga2mcu_pkg
// Shared definitions for the MCU->FPGA DDS word loader: register address map,
// CTRL word bit positions and the loader FSM state type.
package fpga2mcu_pkg;

   localparam logic [2:0] ADDR_FREQ_LO = 3'd0;
   localparam logic [2:0] ADDR_FREQ_HI = 3'd1;
   localparam logic [2:0] ADDR_PHASE   = 3'd2;
   localparam logic [2:0] ADDR_AMP     = 3'd3;
   localparam logic [2:0] ADDR_CTRL    = 3'd4;

   localparam int CTRL_COMMIT = 0;
   localparam int CTRL_OUT_EN = 1;
   localparam int CTRL_CLR    = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WRITE  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/dds_word_loader_toggle_sync.sv
// Module toggle_sync
// Brings the asynchronous write-completion toggle into CLK and turns every
// level change into a single-cycle event.
// Ports:
//   CLK         system clock
//   RST         synchronous, active-high reset (chain and edge flop load 0)
//   toggle_in   asynchronous toggle, one flip per completed MCU write
//   wr_evt      1-CLK pulse per observed toggle level change
module toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic toggle_in,
   output logic wr_evt
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_in};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Two flips closer together than the chain depth can cancel here; that
   // write is silently lost.
   assign wr_evt = sync_q[SYNC_STAGES-1] ^ edge_q;

endmodule

// File: rtl/dds_word_loader.sv
// Module dds_word_loader
// Collects 16-bit MCU writes into shadow DDS tuning registers and, on commit,
// copies every shadow to the active outputs in one cycle with an UPDATE pulse.
// Optional build macro: AUTO_COMMIT_EN -- a FREQ_HI write also commits.
// Ports:
//   CLK, RST            system clock, synchronous active-high reset
//   DATA_IN[15:0]       write data, stable while the write is being captured
//   ADDR_IN[2:0]        register address (0..4 mapped, 5..7 flag WR_ERR)
//   WR_TOGGLE           async toggle, flips once per MCU write
//   FREQ_WORD[31:0]     active frequency word
//   PHASE_WORD[15:0]    active phase word
//   AMP_WORD[AMP_W-1:0] active amplitude word
//   OUT_EN              active output enable
//   UPDATE              1-CLK pulse when the active registers change
//   WR_ERR              sticky unmapped-address flag
//   WR_CNT[CNT_W-1:0]   accepted-write counter, wraps
//
// state    | meaning
// S_IDLE   | waiting for a write event or a buffered pending event
// S_WRITE  | capture DATA_IN/ADDR_IN into the shadow registers
// S_COMMIT | copy shadows to active outputs, pulse UPDATE
module dds_word_loader
   import fpga2mcu_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int AMP_W       = 12,
   parameter int CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [15:0]      DATA_IN,
   input  logic [2:0]       ADDR_IN,
   input  logic             WR_TOGGLE,
   output logic [31:0]      FREQ_WORD,
   output logic [15:0]      PHASE_WORD,
   output logic [AMP_W-1:0] AMP_WORD,
   output logic             OUT_EN,
   output logic             UPDATE,
   output logic             WR_ERR,
   output logic [CNT_W-1:0] WR_CNT
);

   logic             wr_evt;
   logic             pending;
   state_t           state;

   logic [31:0]      freq_sh;
   logic [15:0]      phase_sh;
   logic [AMP_W-1:0] amp_sh;
   logic             out_en_sh;

   toggle_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_toggle_sync (
      .CLK       (CLK),
      .RST       (RST),
      .toggle_in (WR_TOGGLE),
      .wr_evt    (wr_evt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         pending    <= 1'b0;
         freq_sh    <= '0;
         phase_sh   <= '0;
         amp_sh     <= '0;
         out_en_sh  <= 1'b0;
         FREQ_WORD  <= '0;
         PHASE_WORD <= '0;
         AMP_WORD   <= '0;
         OUT_EN     <= 1'b0;
         UPDATE     <= 1'b0;
         WR_ERR     <= 1'b0;
         WR_CNT     <= '0;
      end else begin
         UPDATE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (wr_evt || pending) begin
                  state   <= S_WRITE;
                  pending <= 1'b0;
               end
            end

            S_WRITE: begin
               if (wr_evt) pending <= 1'b1;
               WR_CNT <= WR_CNT + 1'b1;
               state  <= S_IDLE;
               case (ADDR_IN)
                  ADDR_FREQ_LO: freq_sh[15:0] <= DATA_IN;
                  ADDR_FREQ_HI: begin
                     freq_sh[31:16] <= DATA_IN;
`ifdef AUTO_COMMIT_EN
                     state <= S_COMMIT;
`endif
                  end
                  ADDR_PHASE:   phase_sh <= DATA_IN;
                  ADDR_AMP:     amp_sh   <= DATA_IN[AMP_W-1:0];
                  ADDR_CTRL: begin
                     out_en_sh <= DATA_IN[CTRL_OUT_EN];
                     // CLR zeroes the word shadows in this same cycle, so a
                     // combined CLR+COMMIT commits zeros.
                     if (DATA_IN[CTRL_CLR]) begin
                        freq_sh  <= '0;
                        phase_sh <= '0;
                        amp_sh   <= '0;
                     end
                     if (DATA_IN[CTRL_COMMIT]) state <= S_COMMIT;
                  end
                  default: WR_ERR <= 1'b1;
               endcase
            end

            S_COMMIT: begin
               if (wr_evt) pending <= 1'b1;
               FREQ_WORD  <= freq_sh;
               PHASE_WORD <= phase_sh;
               AMP_WORD   <= amp_sh;
               OUT_EN     <= out_en_sh;
               UPDATE     <= 1'b1;
               state      <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_word_loader.sv
module tb_dds_word_loader;

   logic        CLK;
   logic        RST;
   logic [15:0] DATA_IN;
   logic [2:0]  ADDR_IN;
   logic        WR_TOGGLE;
   logic [31:0] FREQ_WORD;
   logic [15:0] PHASE_WORD;
   logic [11:0] AMP_WORD;
   logic        OUT_EN;
   logic        UPDATE;
   logic        WR_ERR;
   logic [7:0]  WR_CNT;

   int n_checks = 0;
   int n_fail   = 0;

   dds_word_loader #(
      .SYNC_STAGES (2),
      .AMP_W       (12),
      .CNT_W       (8)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .DATA_IN    (DATA_IN),
      .ADDR_IN    (ADDR_IN),
      .WR_TOGGLE  (WR_TOGGLE),
      .FREQ_WORD  (FREQ_WORD),
      .PHASE_WORD (PHASE_WORD),
      .AMP_WORD   (AMP_WORD),
      .OUT_EN     (OUT_EN),
      .UPDATE     (UPDATE),
      .WR_ERR     (WR_ERR),
      .WR_CNT     (WR_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One MCU write; counts UPDATE pulses over the following 8 cycles.
   task automatic wr(input logic [2:0] a, input logic [15:0] d, output int upd);
      @(negedge CLK);
      ADDR_IN   = a;
      DATA_IN   = d;
      WR_TOGGLE = ~WR_TOGGLE;
      upd = 0;
      repeat (8) begin
         @(negedge CLK);
         if (UPDATE) upd++;
      end
   endtask

   task automatic test_reset;
      n_checks++;
      if (FREQ_WORD !== 32'h0 || PHASE_WORD !== 16'h0 || AMP_WORD !== 12'h0) begin
         $display("FAIL reset_words: freq=%h phase=%h amp=%h want 0", FREQ_WORD, PHASE_WORD, AMP_WORD);
         n_fail++;
      end
      n_checks++;
      if ({OUT_EN, UPDATE, WR_ERR} !== 3'b000 || WR_CNT !== 8'd0) begin
         $display("FAIL reset_flags: en=%b upd=%b err=%b cnt=%0d want 0", OUT_EN, UPDATE, WR_ERR, WR_CNT);
         n_fail++;
      end
   endtask

   task automatic test_commit_freq;
      int u, total;
      total = 0;
      wr(3'd0, 16'h5678, u); total += u;
      wr(3'd1, 16'h1234, u); total += u;
      wr(3'd4, 16'h0001, u); total += u;
      n_checks++;
      if (FREQ_WORD !== 32'h12345678) begin
         $display("FAIL commit_freq: got %h want 12345678", FREQ_WORD);
         n_fail++;
      end
      n_checks++;
`ifdef AUTO_COMMIT_EN
      if (total !== 2) begin
`else
      if (total !== 1) begin
`endif
         $display("FAIL commit_update_count: got %0d", total);
         n_fail++;
      end
      n_checks++;
      if (WR_CNT !== 8'd3 || OUT_EN !== 1'b0) begin
         $display("FAIL commit_cnt_en: cnt=%0d en=%b want 3/0", WR_CNT, OUT_EN);
         n_fail++;
      end
   endtask

   task automatic test_no_commit;
      int u, total;
      total = 0;
      wr(3'd2, 16'hABCD, u); total += u;
      wr(3'd3, 16'hF321, u); total += u;
      wr(3'd0, 16'h1111, u); total += u;
      n_checks++;
      if (FREQ_WORD !== 32'h12345678 || PHASE_WORD !== 16'h0 || AMP_WORD !== 12'h0 || total !== 0) begin
         $display("FAIL no_commit: freq=%h phase=%h amp=%h upd=%0d want unchanged/0", FREQ_WORD, PHASE_WORD, AMP_WORD, total);
         n_fail++;
      end
      wr(3'd4, 16'h0003, u);
      n_checks++;
      if (FREQ_WORD !== 32'h12341111 || PHASE_WORD !== 16'hABCD || AMP_WORD !== 12'h321 || OUT_EN !== 1'b1) begin
         $display("FAIL shadow_commit: freq=%h phase=%h amp=%h en=%b want 12341111/abcd/321/1", FREQ_WORD, PHASE_WORD, AMP_WORD, OUT_EN);
         n_fail++;
      end
      n_checks++;
      if (u !== 1 || WR_CNT !== 8'd7) begin
         $display("FAIL shadow_commit_upd: upd=%0d cnt=%0d want 1/7", u, WR_CNT);
         n_fail++;
      end
   endtask

   task automatic test_clr_commit;
      int u;
      wr(3'd4, 16'h0007, u);
      n_checks++;
      if (FREQ_WORD !== 32'h0 || PHASE_WORD !== 16'h0 || AMP_WORD !== 12'h0 || OUT_EN !== 1'b1) begin
         $display("FAIL clr_commit: freq=%h phase=%h amp=%h en=%b want 0/0/0/1", FREQ_WORD, PHASE_WORD, AMP_WORD, OUT_EN);
         n_fail++;
      end
      n_checks++;
      if (u !== 1 || WR_CNT !== 8'd8) begin
         $display("FAIL clr_commit_upd: upd=%0d cnt=%0d want 1/8", u, WR_CNT);
         n_fail++;
      end
   endtask

   task automatic test_wr_err;
      int u;
      wr(3'd6, 16'hFFFF, u);
      n_checks++;
      if (WR_ERR !== 1'b1 || u !== 0 || FREQ_WORD !== 32'h0 || OUT_EN !== 1'b1 || WR_CNT !== 8'd9) begin
         $display("FAIL wr_err_set: err=%b upd=%0d freq=%h en=%b cnt=%0d want 1/0/0/1/9", WR_ERR, u, FREQ_WORD, OUT_EN, WR_CNT);
         n_fail++;
      end
      wr(3'd2, 16'h0000, u);
      n_checks++;
      if (WR_ERR !== 1'b1 || WR_CNT !== 8'd10) begin
         $display("FAIL wr_err_sticky: err=%b cnt=%0d want 1/10", WR_ERR, WR_CNT);
         n_fail++;
      end
   endtask

   // Second toggle lands so its event arrives while the FSM is in S_COMMIT.
   task automatic test_back_to_back;
      int u;
      u = 0;
      @(negedge CLK);
      ADDR_IN   = 3'd4;
      DATA_IN   = 16'h0003;
      WR_TOGGLE = ~WR_TOGGLE;
      @(negedge CLK);
      @(negedge CLK);
      WR_TOGGLE = ~WR_TOGGLE;
      @(negedge CLK);
      if (UPDATE) u++;
      @(negedge CLK);
      if (UPDATE) u++;
      ADDR_IN = 3'd2;
      DATA_IN = 16'hBEEF;
      repeat (10) begin
         @(negedge CLK);
         if (UPDATE) u++;
      end
      n_checks++;
      if (WR_CNT !== 8'd12 || u !== 1) begin
         $display("FAIL pending_write: cnt=%0d upd=%0d want 12/1", WR_CNT, u);
         n_fail++;
      end
      wr(3'd4, 16'h0003, u);
      n_checks++;
      if (PHASE_WORD !== 16'hBEEF || u !== 1 || WR_CNT !== 8'd13) begin
         $display("FAIL pending_data: phase=%h upd=%0d cnt=%0d want beef/1/13", PHASE_WORD, u, WR_CNT);
         n_fail++;
      end
   endtask

   task automatic test_auto_commit;
      int u;
      wr(3'd1, 16'h9ABC, u);
      n_checks++;
`ifdef AUTO_COMMIT_EN
      if (u !== 1 || FREQ_WORD !== 32'h9ABC0000) begin
`else
      if (u !== 0 || FREQ_WORD !== 32'h0) begin
`endif
         $display("FAIL auto_commit: upd=%0d freq=%h", u, FREQ_WORD);
         n_fail++;
      end
      n_checks++;
      if (WR_CNT !== 8'd14 || PHASE_WORD !== 16'hBEEF) begin
         $display("FAIL auto_commit_cnt: cnt=%0d phase=%h want 14/beef", WR_CNT, PHASE_WORD);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid;
      int u, total;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      n_checks++;
      if (WR_ERR !== 1'b0 || WR_CNT !== 8'd0 || OUT_EN !== 1'b0 || PHASE_WORD !== 16'h0) begin
         $display("FAIL reset_mid: err=%b cnt=%0d en=%b phase=%h want 0", WR_ERR, WR_CNT, OUT_EN, PHASE_WORD);
         n_fail++;
      end
      total = 0;
      wr(3'd0, 16'h00FF, u); total += u;
      wr(3'd4, 16'h0001, u); total += u;
      n_checks++;
      if (FREQ_WORD !== 32'h000000FF || total !== 1 || WR_CNT !== 8'd2 || PHASE_WORD !== 16'h0) begin
         $display("FAIL after_reset: freq=%h upd=%0d cnt=%0d phase=%h want ff/1/2/0", FREQ_WORD, total, WR_CNT, PHASE_WORD);
         n_fail++;
      end
   endtask

   initial begin
      RST       = 1'b1;
      DATA_IN   = 16'h0;
      ADDR_IN   = 3'd0;
      WR_TOGGLE = 1'b0;
      repeat (3) @(negedge CLK);
      test_reset;
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      test_commit_freq;
      test_no_commit;
      test_clr_commit;
      test_wr_err;
      test_back_to_back;
      test_auto_commit;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
